// File: rtl/finn_rtl_krnl_final_pkg.sv
// rtl/finn_rtl_krnl_final_pkg.sv - shared types and constants for the final pattern generator
package finn_rtl_krnl_final_pkg;

    typedef enum logic [1:0] {
        INCR  = 2'd0,
        CONST = 2'd1,
        LFSR  = 2'd2,
        RSVD  = 2'd3
    } pattern_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] LP_LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/finn_rtl_krnl_final_pattern_lane.sv
// rtl/finn_rtl_krnl_final_pattern_lane.sv - one NB-bit lane of the pattern generator
module finn_rtl_krnl_final_pattern_lane
    import finn_rtl_krnl_final_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          load,
    input  logic          advance,
    input  pattern_mode_t mode,
    input  logic [NB-1:0] init_value,
    input  logic [NB-1:0] step,
    output logic [NB-1:0] data
);

    pattern_mode_t mode_q;
    logic [NB-1:0] value_q;
    logic [31:0]   lfsr_q;
    logic [31:0]   seed;
    logic [31:0]   lfsr_next;

    assign seed      = 32'(init_value);
    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LP_LFSR_POLY) : (lfsr_q >> 1);

    always_ff @(posedge aclk) begin
        if (areset) begin
            mode_q  <= INCR;
            value_q <= '0;
            lfsr_q  <= '0;
        end else if (load) begin
            mode_q  <= mode;
            value_q <= init_value;
            // An all-zero LFSR state would lock up, so a zero seed becomes 1
            lfsr_q  <= (seed == 32'd0) ? 32'd1 : seed;
        end else if (advance) begin
            case (mode_q)
                CONST:   value_q <= value_q;
                LFSR:    lfsr_q  <= lfsr_next;
                default: value_q <= value_q + step;
            endcase
        end
    end

    assign data = (mode_q == LFSR) ? NB'(lfsr_q) : value_q;

endmodule

// File: rtl/finn_rtl_krnl_final_pattern_generator.sv
// rtl/finn_rtl_krnl_final_pattern_generator.sv - configurable AXI4-Stream test-pattern source
module finn_rtl_krnl_final_pattern_generator
    import finn_rtl_krnl_final_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 128,
    parameter int C_NUMBER_BIT_WIDTH   = 32,
    parameter int C_LENGTH_WIDTH       = 32
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              ap_start,
    output logic                              ap_idle,
    output logic                              ap_done,
    input  logic [1:0]                        cfg_mode,
    input  logic [C_LENGTH_WIDTH-1:0]         cfg_length_bytes,
    input  logic [C_NUMBER_BIT_WIDTH-1:0]     cfg_start_value,
    input  logic [C_NUMBER_BIT_WIDTH-1:0]     cfg_stride,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                              m_axis_tlast
);

    localparam int NB       = C_NUMBER_BIT_WIDTH;
    localparam int LW       = C_LENGTH_WIDTH;
    localparam int LP_LANES = C_M_AXIS_TDATA_WIDTH / NB;
    localparam int LP_BYTES = C_M_AXIS_TDATA_WIDTH / 8;
    localparam logic [LW-1:0] LP_BYTES_LEN = LW'(LP_BYTES);
    localparam logic [NB-1:0] LP_LANES_NB  = NB'(LP_LANES);

    state_t                state_q, state_d;
    pattern_mode_t         cfg_mode_e;
    logic                  start_q;
    logic                  go;
    logic                  handshake;
    logic [LW-1:0]         beat_cnt_q;
    logic [LW-1:0]         len_rem;
    logic [NB-1:0]         stride_q;
    logic [NB-1:0]         lane_step;
    logic [LP_BYTES-1:0]   last_keep_d, last_keep_q;

    assign cfg_mode_e = pattern_mode_t'(cfg_mode);
    assign go         = ap_start & ~start_q & (state_q == IDLE);
    assign handshake  = m_axis_tvalid & m_axis_tready;
    assign len_rem    = cfg_length_bytes % LP_BYTES_LEN;
    assign lane_step  = stride_q * LP_LANES_NB;

    always_comb begin
        last_keep_d = '1;
        for (int i = 0; i < LP_BYTES; i++) begin
            last_keep_d[i] = (len_rem == '0) || (LW'(i) < len_rem);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            start_q     <= 1'b0;
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            stride_q    <= '0;
            last_keep_q <= '1;
        end else begin
            start_q <= ap_start;
            state_q <= state_d;
            if (go) begin
                // Counter value is meaningless for len==0; that path never enters RUN
                beat_cnt_q  <= (cfg_length_bytes - 1'b1) / LP_BYTES_LEN;
                stride_q    <= cfg_stride;
                last_keep_q <= last_keep_d;
            end else if (handshake) begin
                beat_cnt_q <= beat_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ap_idle       = 1'b0;
        ap_done       = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                ap_idle = 1'b1;
                if (go) state_d = (cfg_length_bytes == '0) ? DONE : RUN;
            end
            RUN: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (beat_cnt_q == '0);
                if (handshake && m_axis_tlast) state_d = DONE;
            end
            DONE: begin
                ap_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_axis_tkeep = m_axis_tlast ? last_keep_q : '1;

    for (genvar k = 0; k < LP_LANES; k++) begin : g_lane
        logic [NB-1:0] lane_idx;
        logic [NB-1:0] init_value;

        assign lane_idx = NB'(k);

        always_comb begin
            init_value = cfg_start_value + lane_idx * cfg_stride;
            case (cfg_mode_e)
                CONST:   init_value = cfg_start_value;
                LFSR:    init_value = cfg_start_value + lane_idx;
                default: init_value = cfg_start_value + lane_idx * cfg_stride;
            endcase
        end

        finn_rtl_krnl_final_pattern_lane #(
            .NB (NB)
        ) u_lane (
            .aclk       (aclk),
            .areset     (areset),
            .load       (go),
            .advance    (handshake),
            .mode       (cfg_mode_e),
            .init_value (init_value),
            .step       (lane_step),
            .data       (m_axis_tdata[k*NB +: NB])
        );
    end

endmodule

// File: tb/tb_finn_rtl_krnl_final_pattern_generator.sv
// tb/tb_finn_rtl_krnl_final_pattern_generator.sv - scoreboard bench for the final pattern generator
module tb_finn_rtl_krnl_final_pattern_generator;

    localparam int TW = 128;
    localparam int NB = 32;
    localparam int LW = 32;
    localparam int L  = TW / NB;
    localparam int B  = TW / 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          ap_start = 1'b0;
    logic          ap_idle, ap_done;
    logic [1:0]    cfg_mode = 2'd0;
    logic [LW-1:0] cfg_length_bytes = '0;
    logic [NB-1:0] cfg_start_value = '0;
    logic [NB-1:0] cfg_stride = '0;
    logic          tvalid;
    logic          tready = 1'b1;
    logic [TW-1:0] tdata;
    logic [B-1:0]  tkeep;
    logic          tlast;

    always #5 aclk = ~aclk;

    finn_rtl_krnl_final_pattern_generator #(
        .C_M_AXIS_TDATA_WIDTH (TW),
        .C_NUMBER_BIT_WIDTH   (NB),
        .C_LENGTH_WIDTH       (LW)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .ap_start         (ap_start),
        .ap_idle          (ap_idle),
        .ap_done          (ap_done),
        .cfg_mode         (cfg_mode),
        .cfg_length_bytes (cfg_length_bytes),
        .cfg_start_value  (cfg_start_value),
        .cfg_stride       (cfg_stride),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .m_axis_tdata     (tdata),
        .m_axis_tkeep     (tkeep),
        .m_axis_tlast     (tlast)
    );

    typedef struct packed {
        logic [TW-1:0] data;
        logic [B-1:0]  keep;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [TW-1:0] got_data[$];
    logic [B-1:0]  got_keep[$];
    beat_t         mon_e;
    logic          stall_prev = 1'b0;
    beat_t         stall_beat;
    int vectors = 0, miscompares = 0;
    int hs_count = 0, done_count = 0, valid_count = 0;
    int ready_mode = 0;

    function automatic void check(string name, logic [255:0] act, logic [255:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] lfsr_step(logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [TW-1:0] got_beat(int i);
        if (got_data.size() > i) return got_data[i];
        return 'x;
    endfunction

    // Reference model: expected beats for one transfer
    task automatic push_expected(int mode, int len, logic [31:0] start, logic [31:0] stride);
        int n = (len + B - 1) / B;
        int r = len % B;
        logic [31:0] lf[L];
        beat_t e;
        for (int k = 0; k < L; k++) begin
            lf[k] = start + k;
            if (lf[k] == 32'd0) lf[k] = 32'd1;
        end
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < L; k++) begin
                case (mode)
                    1:       e.data[k*NB +: NB] = start;
                    2:       e.data[k*NB +: NB] = lf[k];
                    default: e.data[k*NB +: NB] = start + (b * L + k) * stride;
                endcase
                lf[k] = lfsr_step(lf[k]);
            end
            for (int i = 0; i < B; i++) e.keep[i] = (b != n - 1) || (r == 0) || (i < r);
            e.last = (b == n - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(posedge aclk) begin
        #1;
        case (ready_mode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge aclk) begin
        if (!areset && tvalid) begin
            valid_count++;
            if (stall_prev) check("stall_hold", {tdata, tkeep, tlast}, stall_beat);
            if (tready) begin
                hs_count++;
                got_data.push_back(tdata);
                got_keep.push_back(tkeep);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tdata", tdata, mon_e.data);
                    check("tkeep", tkeep, mon_e.keep);
                    check("tlast", tlast, mon_e.last);
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                stall_beat = {tdata, tkeep, tlast};
            end
        end else begin
            stall_prev = 1'b0;
        end
        if (ap_done) done_count++;
    end

    task automatic run(string name, int mode, int len, logic [31:0] start, logic [31:0] stride,
                       int rmode, bit check_timing, bit hold_start);
        int cyc = 0;
        int d0;
        int n = (len + B - 1) / B;
        ready_mode = rmode;
        got_data.delete();
        got_keep.delete();
        push_expected(mode, len, start, stride);
        ap_start = 1'b0;
        @(posedge aclk); #1;
        cfg_mode = 2'(mode);
        cfg_length_bytes = LW'(len);
        cfg_start_value = start;
        cfg_stride = stride;
        ap_start = 1'b1;
        d0 = done_count;
        while (done_count == d0 && cyc < 2000) begin
            @(posedge aclk);
            cyc++;
            @(negedge aclk); #1;
            if (cyc == 1) begin
                if (check_timing && len > 0) check({name, "_idle_fall"}, ap_idle, 0);
                cfg_mode = 2'd2;
                cfg_length_bytes = 32'd999;
                cfg_start_value = 32'h5555_AAAA;
                cfg_stride = 32'd77;
            end
        end
        check({name, "_done_seen"}, done_count - d0, 1);
        if (check_timing) check({name, "_done_cycle"}, cyc, n + 1);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        if (!hold_start) ap_start = 1'b0;
        @(posedge aclk);
        @(negedge aclk); #1;
        check({name, "_idle_after"}, ap_idle, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, d0, v0, cyc;
        logic [TW-1:0] bt;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk); #1;
        check("rst_idle", ap_idle, 1);
        check("rst_done", ap_done, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tkeep", tkeep, 16'hFFFF);

        // Test 1: INCR basic
        run("t1", 0, 64, 32'd0, 32'd1, 0, 1'b1, 1'b0);
        bt = got_beat(0);
        check("t1_beat0", bt, {32'd3, 32'd2, 32'd1, 32'd0});
        bt = got_beat(3);
        check("t1_beat3", bt, {32'd15, 32'd14, 32'd13, 32'd12});

        // Test 2: partial tail under random ready
        run("t2", 0, 20, 32'd5, 32'd2, 2, 1'b0, 1'b0);
        check("t2_beats", got_keep.size(), 2);
        if (got_keep.size() == 2) check("t2_tail_keep", got_keep[1], 16'h000F);

        // Test 3: backpressure
        run("t3", 0, 48, 32'd100, 32'd3, 1, 1'b0, 1'b0);
        check("t3_beats", got_data.size(), 3);
        bt = got_beat(0);
        check("t3_beat0", bt, {32'd109, 32'd106, 32'd103, 32'd100});
        bt = got_beat(2);
        check("t3_beat2_lane0", bt[31:0], 32'd124);

        // Test 4: LFSR and CONST
        run("t4_lfsr", 2, 32, 32'd0, 32'd0, 0, 1'b1, 1'b0);
        bt = got_beat(0);
        check("t4_lfsr_beat0", bt, {32'd3, 32'd2, 32'd1, 32'd1});
        bt = got_beat(1);
        check("t4_lfsr_beat1_lane0", bt[31:0], 32'h8020_0003);
        run("t4_const", 1, 40, 32'hDEAD_BEEF, 32'd9, 1, 1'b0, 1'b0);
        bt = got_beat(2);
        check("t4_const_beat2", bt, {4{32'hDEAD_BEEF}});
        run("t4_rsvd", 3, 16, 32'd10, 32'd5, 0, 1'b1, 1'b0);

        // Test 5: zero length and held start
        v0 = valid_count;
        run("t5_zero", 0, 0, 32'd0, 32'd1, 0, 1'b1, 1'b0);
        check("t5_zero_no_valid", valid_count - v0, 0);
        run("t5_held", 0, 16, 32'd7, 32'd1, 0, 1'b1, 1'b1);
        h0 = hs_count;
        d0 = done_count;
        repeat (10) @(posedge aclk);
        @(negedge aclk); #1;
        check("t5_held_no_beats", hs_count - h0, 0);
        check("t5_held_no_done", done_count - d0, 0);
        check("t5_held_idle", ap_idle, 1);
        run("t5_retoggle", 0, 16, 32'd7, 32'd1, 0, 1'b1, 1'b0);

        // Test 6: reset mid-transfer, then wrap
        ready_mode = 0;
        push_expected(0, 128, 32'd0, 32'd1);
        ap_start = 1'b0;
        @(posedge aclk); #1;
        cfg_mode = 2'd0;
        cfg_length_bytes = 32'd128;
        cfg_start_value = 32'd0;
        cfg_stride = 32'd1;
        ap_start = 1'b1;
        h0 = hs_count;
        cyc = 0;
        while (hs_count < h0 + 2 && cyc < 100) begin
            @(posedge aclk); @(negedge aclk); #1;
            cyc++;
        end
        check("t6_reach_beat2", hs_count >= h0 + 2, 1);
        d0 = done_count;
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk); #1;
        check("t6_rst_tvalid", tvalid, 0);
        check("t6_rst_idle", ap_idle, 1);
        check("t6_rst_done", ap_done, 0);
        check("t6_rst_tlast", tlast, 0);
        areset = 1'b0;
        ap_start = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge aclk);
        @(negedge aclk); #1;
        check("t6_no_done_after_rst", done_count - d0, 0);
        check("t6_still_idle", ap_idle, 1);
        run("t6_wrap", 0, 16, 32'hFFFF_FFFE, 32'd1, 0, 1'b1, 1'b0);
        bt = got_beat(0);
        check("t6_wrap_beat0", bt, {32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/finn_rtl_krnl_final_pattern_generator.md
# finn_rtl_krnl_final_pattern_generator

Runtime-configurable AXI4-Stream test-pattern source for the kernel's stream path; successor to the fixed incrementing-number source. Per transfer it takes a byte length, mode, start value and stride, then emits the pattern across `C_M_AXIS_TDATA_WIDTH/C_NUMBER_BIT_WIDTH` lanes. Backpressure is honoured exactly, and `tkeep` is trimmed on a partial final beat. It feeds the FINN datapath and hash checker during bring-up and regression.

## Interface
- `C_M_AXIS_TDATA_WIDTH`, 128: stream width in bits; a multiple of `C_NUMBER_BIT_WIDTH`, and at least 8.
- `C_NUMBER_BIT_WIDTH`, 32: lane width NB. Lane count is L = TDATA/NB.
- `C_LENGTH_WIDTH`, 32: width of `cfg_length_bytes`.
- `aclk`, in, 1: clock.
- `areset`, in, 1: reset; synchronous, active-high. The clock is `aclk`.
- `ap_start`, in, 1: a rising edge requests a transfer.
- `ap_idle`, out, 1: high in IDLE.
- `ap_done`, out, 1: one-cycle pulse at the end of a transfer.
- `cfg_mode`, in, 2: 0=INCR, 1=CONST, 2=LFSR, 3=reserved (behaves as INCR).
- `cfg_length_bytes`, in, C_LENGTH_WIDTH: transfer length in bytes.
- `cfg_start_value`, in, NB: base value or seed.
- `cfg_stride`, in, NB: INCR step per number.
- `m_axis_tvalid`, out, 1: AXI4-Stream valid.
- `m_axis_tready`, in, 1: AXI4-Stream ready.
- `m_axis_tdata`, out, TDATA: AXI4-Stream data.
- `m_axis_tkeep`, out, TDATA/8: AXI4-Stream byte keep.
- `m_axis_tlast`, out, 1: AXI4-Stream last.

## Operation
- `go` is asserted when `ap_start` is high, `ap_start` was low in the previous cycle (edge register), and the FSM is in IDLE. Edges seen outside IDLE are ignored and are not queued.
- On `go`, all `cfg_*` inputs are captured into registers. Config changes during a transfer have no effect.
- Beat count N = ceil(len/B), where B = TDATA/8.
- Bytes in the final beat R = len mod B. If R≠0, the final `tkeep` is `(1<<R)-1`; on every other beat `tkeep` is all ones.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `go` when len≠0.
  - IDLE → DONE on `go` when len==0; no beats are emitted.
  - RUN → DONE on a handshake (`tvalid & tready`) when `tlast` is high.
  - DONE → IDLE unconditionally. `ap_done` is high only in DONE.
- The beat counter is loaded with N-1 on `go` and decrements on a handshake only. `tlast` = RUN and counter==0.
- Lane k (k=0..L-1) occupies `tdata[k*NB +: NB]`. All arithmetic is modulo 2^NB.
  - INCR: initial value is start + k·stride. Each handshake adds L·stride.
  - CONST: every lane holds start on every beat.
  - LFSR: each lane is a 32-bit Galois LFSR. NB≠32 uses the low NB bits of the state.
    - Polynomial: 0x80200003, shifting right with XOR of the mask when the LSB is 1.
    - Seed: start + k. A zero seed is replaced by 1.
    - One step per handshake.
- Lane registers advance only on a handshake.

## Timing
- Reset values:
  - FSM in IDLE.
  - `ap_idle`=1.
  - `ap_done`, `m_axis_tvalid`, `m_axis_tlast` = 0.
  - `m_axis_tdata` = 0.
  - `m_axis_tkeep` = all ones.
  - Edge register = 0.
- `go` is evaluated in cycle 0. The first beat is valid in cycle 1, and `ap_idle` falls in cycle 1.
- Throughput is one beat per cycle with `tready` held high. For len>0 with no stalls, `ap_done` pulses in cycle N+1 and `ap_idle` is high again in cycle N+2.
- For len==0, `ap_done` is high in cycle 1.
- While `tvalid` is high and `tready` is low, `tdata`, `tkeep` and `tlast` are held stable. `tvalid` never drops before its handshake.
- Edge cases:
  - N==1: the first beat carries `tlast`.
  - The counter wraps modulo 2^NB without a flag.
  - `ap_start` held high across DONE→IDLE does not restart; a new low→high edge is required.
  - Reset asserted mid-transfer: return to reset values next cycle, with no `ap_done` and no `tlast`.

## Structure
- Package `finn_rtl_krnl_final_pkg` holds:
  - `pattern_mode_t` enum (INCR, CONST, LFSR, RSVD).
  - `state_t` enum (IDLE, RUN, DONE).
  - LFSR polynomial constant `LP_LFSR_POLY`.
- Sub-module `finn_rtl_krnl_final_pattern_lane` (parameter NB; inputs `load`, `advance`, mode, init value, step) is instantiated L times by generate. The top holds the FSM, beat counter and `tkeep`/`tlast` logic.

## Test plan
- Test 1, INCR basic: defaults, start=0, stride=1, len=64, `tready`=1.
  - Expect 4 beats; beat0 lanes = {0,1,2,3}, beat3 = {12,13,14,15}.
  - Expect `tlast` only on beat 3 and `ap_done` in cycle 5.
- Test 2, partial tail: INCR, len=20.
  - Expect 2 beats; final `tkeep`=16'h000F; both `tlast` and `tkeep` correct under random `tready`.
- Test 3, backpressure: INCR, start=100, stride=3, len=48, `tready` toggling 1010….
  - `tdata` stays stable across stalls; beats are {100,103,106,109}, {112,…}, {124,…}.
  - No beat is lost or duplicated.
- Test 4, LFSR and CONST:
  - LFSR, start=0, len=32: lane0 seed replaced by 1, so lane0 of beat1 = 0x80200003.
  - CONST, start=0xDEADBEEF: every lane of every beat is 0xDEADBEEF.
- Test 5, zero-length and restart:
  - len=0: no `tvalid`, and `ap_done` one cycle after `go`.
  - `ap_start` held high: no second transfer until it is toggled low then high.
- Test 6, reset and wrap:
  - Reset asserted at beat 2 of 8: `tvalid`=0 and `ap_idle`=1 next cycle, and no `ap_done`.
  - INCR, start=0xFFFFFFFE, stride=1: lanes wrap to {…,0,1}.
